// File: rtl/led_matrix_scanner_if.sv
// Frame input and LED driver outputs of the 8x8 RGB matrix scanner.
// master = the scanner, slave = whoever supplies the frame and watches the pins.
interface led_matrix_scanner_if;
  logic             enable;
  logic [7:0][23:0] board;
  logic             sh_data;
  logic             sh_clk;
  logic             sh_latch;
  logic [7:0]       row_en;
  logic [2:0]       row_idx;
  logic             frame_done;
  logic             busy;

  modport master (
    input  enable, board,
    output sh_data, sh_clk, sh_latch, row_en, row_idx, frame_done, busy
  );

  modport slave (
    output enable, board,
    input  sh_data, sh_clk, sh_latch, row_en, row_idx, frame_done, busy
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for an 8x8 RGB matrix. Shifts each row's 24 column bits
// into external shift registers (MSB first), latches them, then lights the row.
// The frame is snapshotted at every row-0 load so a refresh never tears.
module led_matrix_scanner #(
  parameter int CLK_DIV  = 4,
  parameter int ROW_HOLD = 1000
) (
  input logic                  clk,
  input logic                  reset,
  led_matrix_scanner_if.master bus
);
  // One shared counter covers the shift bit period, the latch strobe and the dwell.
  localparam int CNT_MAX = (ROW_HOLD > 2*CLK_DIV) ? ROW_HOLD : 2*CLK_DIV;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] SHIFT_LAST = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(ROW_HOLD - 1);
  localparam logic [CW-1:0] HI_START   = CW'(CLK_DIV);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DISPLAY} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [4:0]       bit_ptr, bit_n;
  logic [2:0]       row, row_n;
  logic [7:0][23:0] snap, snap_n;
  logic             done_n;

  logic       sh_data_q, sh_clk_q, sh_latch_q, frame_done_q, busy_q;
  logic [7:0] row_en_q;
  logic       sh_data_n, sh_clk_n, sh_latch_n, busy_n;
  logic [7:0] row_en_n;

  // Next-state, counter and snapshot logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_ptr;
    row_n   = row;
    snap_n  = snap;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_n = LOAD;
          row_n   = '0;
          cnt_n   = '0;
        end
      end
      LOAD: begin
        if (row == 3'd0) snap_n = bus.board;
        state_n = SHIFT;
        bit_n   = 5'd23;
        cnt_n   = '0;
      end
      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          cnt_n = '0;
          if (bit_ptr == 5'd0) state_n = LATCH;
          else                 bit_n   = bit_ptr - 5'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          cnt_n   = '0;
          state_n = DISPLAY;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DISPLAY: begin
        if (cnt == HOLD_LAST) begin
          cnt_n  = '0;
          done_n = (row == 3'd7);
          row_n  = row + 3'd1;
          if (bus.enable) begin
            state_n = LOAD;
          end else begin
            state_n = IDLE;
            row_n   = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output values for the state being entered, so the pins are plain flops.
  always_comb begin
    sh_data_n  = 1'b0;
    sh_clk_n   = 1'b0;
    sh_latch_n = 1'b0;
    row_en_n   = '0;
    busy_n     = (state_n != IDLE);
    case (state_n)
      SHIFT: begin
        sh_data_n = snap_n[row_n][bit_n];
        sh_clk_n  = (cnt_n >= HI_START);
      end
      LATCH:   sh_latch_n = 1'b1;
      DISPLAY: row_en_n   = 8'b1 << row_n;
      default: ;
    endcase
  end

  // State, counters, snapshot and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_ptr      <= '0;
      row          <= '0;
      snap         <= '0;
      sh_data_q    <= 1'b0;
      sh_clk_q     <= 1'b0;
      sh_latch_q   <= 1'b0;
      row_en_q     <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_ptr      <= bit_n;
      row          <= row_n;
      snap         <= snap_n;
      sh_data_q    <= sh_data_n;
      sh_clk_q     <= sh_clk_n;
      sh_latch_q   <= sh_latch_n;
      row_en_q     <= row_en_n;
      frame_done_q <= done_n;
      busy_q       <= busy_n;
    end
  end

  assign bus.sh_data    = sh_data_q;
  assign bus.sh_clk     = sh_clk_q;
  assign bus.sh_latch   = sh_latch_q;
  assign bus.row_en     = row_en_q;
  assign bus.row_idx    = row;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: a scoreboard of expected latched rows
// is filled as frames are driven and drained by a pin-level shift monitor.
module tb_led_matrix_scanner;
  localparam int CLK_DIV   = 2;
  localparam int ROW_HOLD  = 10;
  localparam int ROW_CYC   = 1 + 48*CLK_DIV + CLK_DIV + ROW_HOLD;
  localparam int FRAME_CYC = 8*ROW_CYC;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  led_matrix_scanner_if bus();

  led_matrix_scanner #(.CLK_DIV(CLK_DIV), .ROW_HOLD(ROW_HOLD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]  row;
    logic [23:0] word;
  } exp_t;

  exp_t             sb[$];
  exp_t             e;
  logic [7:0][23:0] img;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected rows for the next nrows latches, taken from the frame just driven.
  task automatic push(input int nrows);
    for (int r = 0; r < nrows; r++) sb.push_back({3'(r % 8), img[r % 8]});
  endtask

  // Pin monitor: rebuild each shifted word, score it at the latch, check invariants.
  initial begin
    logic        prev_clk, prev_latch, prev_data;
    logic [23:0] shreg;
    int          nbits;
    prev_clk = 1'b0; prev_latch = 1'b0; prev_data = 1'b0; shreg = '0; nbits = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        nbits = 0;
      end else begin
        if (bus.sh_clk && !prev_clk) begin
          shreg = {shreg[22:0], bus.sh_data};
          nbits++;
        end
        if (bus.sh_latch && !prev_latch) begin
          chk("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("latch_row", bus.row_idx, e.row);
            chk("latch_word", shreg, e.word);
            chk("latch_bits", nbits, 24);
          end
          nbits = 0;
        end
        chk("row_en_onehot", 32'((bus.row_en & (bus.row_en - 8'd1)) == 8'd0), 1);
        if (bus.sh_clk || bus.sh_latch) chk("blank_when_shift", bus.row_en, 0);
        if (bus.sh_clk && prev_clk) chk("data_stable", bus.sh_data, prev_data);
      end
      prev_clk   = bus.sh_clk;
      prev_latch = bus.sh_latch;
      prev_data  = bus.sh_data;
    end
  end

  initial begin
    int t_load, t_row, t_fd, n;
    bus.enable = 1'b0;
    img = '0;
    bus.board = img;
    reset = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_row_en", bus.row_en, 0);
    chk("rst_row_idx", bus.row_idx, 0);
    chk("rst_pins", {bus.sh_data, bus.sh_clk, bus.sh_latch, bus.frame_done}, 0);

    // Frame 1: row 0 carries the A5_00_3C pattern, rows 1-7 a walking one
    img[0] = 24'hA5003C;
    for (int r = 1; r < 8; r++) img[r] = 24'h1 << r;
    bus.board = img;
    push(8);
    reset = 1'b0;
    bus.enable = 1'b1;
    for (n = 0; n < 10 && !bus.busy; n++) step();
    t_load = cyc;
    chk("load_busy", bus.busy, 1);
    chk("load_row_idx", bus.row_idx, 0);
    chk("load_blank", bus.row_en, 0);

    for (n = 0; n < 200 && !bus.sh_latch; n++) step();
    chk("latch_time", cyc - t_load, 1 + 48*CLK_DIV);
    for (n = 0; n < 20 && bus.sh_latch; n++) step();
    chk("latch_width", n, CLK_DIV);
    chk("row0_en", bus.row_en, 8'h01);
    t_row = cyc;
    for (n = 0; n < ROW_HOLD + 5 && bus.row_en == 8'h01; n++) step();
    chk("row0_dwell", n, ROW_HOLD);

    for (int r = 1; r < 8; r++) begin
      for (n = 0; n < ROW_CYC + 5 && bus.row_en != (8'h1 << r); n++) step();
      chk($sformatf("row%0d_start", r), cyc - t_row, r*ROW_CYC);
      chk($sformatf("row%0d_idx", r), bus.row_idx, r);
    end

    for (n = 0; n < ROW_CYC && !bus.frame_done; n++) step();
    chk("frame1_done_time", cyc - t_load, FRAME_CYC);
    chk("frame1_wrap", bus.row_idx, 0);
    t_fd = cyc;
    push(8);
    step();
    chk("frame_done_pulse", bus.frame_done, 0);

    // Frame 2: change row 5 while row 2 shifts; it must wait for frame 3
    for (n = 0; n < 2*ROW_CYC && bus.row_idx != 3'd2; n++) step();
    repeat (6) step();
    chk("row2_shifting", {bus.row_idx, bus.row_en}, {3'd2, 8'h00});
    img[5] = 24'h5A5A5A;
    bus.board = img;
    for (n = 0; n < FRAME_CYC + 10 && !bus.frame_done; n++) step();
    chk("frame2_period", cyc - t_fd, FRAME_CYC);
    t_fd = cyc;
    push(8);
    step();

    // Frame 3 shows the new row 5; frame 4 drops enable during row 3 shift
    for (n = 0; n < FRAME_CYC + 10 && !bus.frame_done; n++) step();
    chk("frame3_period", cyc - t_fd, FRAME_CYC);
    push(4);
    step();
    for (n = 0; n < FRAME_CYC && bus.row_idx != 3'd3; n++) step();
    repeat (6) step();
    chk("row3_shifting", {bus.row_idx, bus.row_en}, {3'd3, 8'h00});
    bus.enable = 1'b0;
    for (n = 0; n < ROW_CYC + 5 && bus.row_en != 8'h08; n++) step();
    for (n = 0; n < ROW_HOLD + 5 && bus.row_en == 8'h08; n++) step();
    chk("row3_dwell", n, ROW_HOLD);
    chk("stop_busy", bus.busy, 0);
    chk("stop_row_en", bus.row_en, 0);
    chk("stop_row_idx", bus.row_idx, 0);
    chk("stop_sb_drained", sb.size(), 0);
    repeat (20) step();
    chk("stay_idle", bus.busy, 0);

    // Reset during row 4 display, then restart with a fresh frame
    for (int r = 0; r < 8; r++) img[r] = 24'h123456 ^ (24'(r) * 24'h0F0F0F);
    bus.board = img;
    push(5);
    bus.enable = 1'b1;
    for (n = 0; n < FRAME_CYC && bus.row_en != 8'h10; n++) step();
    chk("row4_display", bus.row_en, 8'h10);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rrst_row_en", bus.row_en, 0);
    chk("rrst_sh", {bus.sh_clk, bus.sh_latch}, 0);
    chk("rrst_busy", bus.busy, 0);
    chk("rrst_sb_drained", sb.size(), 0);
    for (int r = 0; r < 8; r++) img[r] = ~img[r];
    bus.board = img;
    push(25);
    step();
    reset = 1'b0;
    for (n = 0; n < 10 && !bus.busy; n++) step();
    t_load = cyc;
    chk("restart_busy", bus.busy, 1);
    chk("restart_row_idx", bus.row_idx, 0);

    // Three full frames under the monitor's invariants, then stop after one row
    for (int f = 0; f < 3; f++) begin
      for (n = 0; n < FRAME_CYC + 10 && !bus.frame_done; n++) step();
      chk($sformatf("run_frame%0d", f), cyc - t_load, (f + 1)*FRAME_CYC);
      if (f == 2) bus.enable = 1'b0;
      step();
    end
    for (n = 0; n < ROW_CYC + 10 && bus.busy; n++) step();
    chk("final_idle", bus.busy, 0);
    chk("final_sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Drives the 8x8 RGB LED matrix from the packed frame produced by the display mapper: 8 rows × 24 bits, where bits 7:0 are blue, 15:8 green and 23:16 red.
- Row by row, shifts each row's 24 column bits serially into the external column shift registers, latches them, then enables that row for a fixed dwell time.
- Snapshots the whole frame once per refresh so a displayed frame never mixes two game states.

Parameters:
- CLK_DIV, 4: shift-clock half-period in clk cycles (≥1).
- ROW_HOLD, 1000: row-on dwell in clk cycles (≥1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  scanning permitted; sampled at the IDLE and end-of-DISPLAY decision points
- board  input  8x24 (packed [7:0][23:0])  frame from the display mapper; row r = board[r]
- sh_data  output  1  serial column data
- sh_clk  output  1  shift clock to the column registers (data sampled on rising edge)
- sh_latch  output  1  storage-register latch strobe, active-high
- row_en  output  8  one-hot row enable, active-high; all-zero = blanked
- row_idx  output  3  row currently being loaded or displayed
- frame_done  output  1  one-cycle pulse when row 7 dwell completes
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset, synchronous: state=IDLE; all outputs 0; row_idx=0; snapshot register cleared; internal counters 0. Reset asserted in any state takes effect on the next edge and blanks row_en that same edge.
- Registered outputs: every output changes only on a clk edge.

State machine (states in order):
- IDLE: all outputs low. If enable=1 → LOAD with row_idx=0.
- LOAD (1 cycle): row_en=0. If row_idx==0, copy board into the snapshot register; rows 1–7 use the existing snapshot → SHIFT, bit pointer=23.
- SHIFT: 24 bits, MSB first, snapshot[row_idx][23] down to [0].
  - Each bit is CLK_DIV cycles with sh_clk=0, then CLK_DIV cycles with sh_clk=1.
  - sh_data updates on the first cycle of the low phase and holds through the high phase.
  - After bit 0's high phase, sh_clk=0 → LATCH.
  - row_en=0 throughout.
- LATCH: sh_latch=1 for CLK_DIV cycles; sh_clk=0; row_en=0 → DISPLAY.
- DISPLAY: row_en = one-hot(row_idx) for ROW_HOLD cycles; sh_latch=0. On the last cycle:
  - If row_idx==7: frame_done=1 for exactly the following cycle, row_idx wraps to 0.
  - Otherwise row_idx increments.
  - Then if enable=1 → LOAD; else → IDLE, with row_en=0 and row_idx=0.
- Row timing: 1 + 48·CLK_DIV + CLK_DIV + ROW_HOLD cycles per row; a frame is 8× that.

Boundary conditions:
- enable dropped mid-row: the current row completes SHIFT, LATCH and DISPLAY, then the block goes IDLE. It never stops mid-shift.
- enable re-asserted after IDLE: the scan restarts at row 0 with a fresh snapshot.
- board changes during a frame: ignored until the next row-0 LOAD, so no tearing.
- Blanking: row_en is zero at every cycle outside DISPLAY; two rows are never enabled at once.
- Counter widths: sized to hold ROW_HOLD−1 and 2·CLK_DIV−1 with no overflow. Counters reload rather than wrap.

Test Plan:
1. CLK_DIV=2, ROW_HOLD=10; reset held 3 cycles, then enable=1, board[0]=24'hA5_00_3C (red A5, green 00, blue 3C) → exactly 24 sh_clk rising edges. The sh_data values sampled at those edges read 1010_0101_0000_0000_0011_1100. sh_latch is high for 2 cycles, then row_en=8'h01 for 10 cycles. Row period is 109 cycles.
2. Full frame with board[r]=24'h000001<<r → on each row's latch the captured word equals board[r]. row_en steps 01,02,…,80. frame_done pulses once after row 7, 872 cycles after the first LOAD, and row_idx wraps to 0.
3. Snapshot test: change board[5] while row 2 is shifting → row 5 of the current frame still shows the old value. The new value appears in the next frame.
4. enable deasserted during row 3 SHIFT → row 3 completes its dwell (row_en=8'h08 for ROW_HOLD cycles), then busy=0, row_en=0, row_idx=0.
5. reset asserted during DISPLAY of row 4 → the next edge shows row_en=0, sh_clk=0, sh_latch=0, busy=0. After release with enable=1 the scan restarts at row 0.
6. Invariant checks over a 3-frame run: row_en is zero-or-one-hot every cycle; row_en=0 whenever sh_clk or sh_latch is active; sh_data is stable while sh_clk=1.
